// File: rtl/sum_seq_ctrl.sv
// Mini-batch sequencer for the range-BN sum cell: per-channel mean/max/min/range.
// Optional SUM_SEQ_ADDR_CHECK_EN adds a sticky channel-address mismatch flag.
module sum_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MINI_BATCH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] dp_x,
    output logic [DATA_WIDTH-1:0] dp_partsum,
    output logic [DATA_WIDTH-1:0] dp_max,
    output logic [DATA_WIDTH-1:0] dp_min,
    output logic                  dp_valid,
    output logic [ADDR_WIDTH-1:0] dp_addr,
    input  logic [DATA_WIDTH-1:0] dp_partsum_r,
    input  logic [DATA_WIDTH-1:0] dp_max_r,
    input  logic [DATA_WIDTH-1:0] dp_min_r,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_mean,
    output logic [DATA_WIDTH-1:0] m_max,
    output logic [DATA_WIDTH-1:0] m_min,
    output logic [DATA_WIDTH-1:0] m_range,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  err
);
    localparam int SHIFT = $clog2(MINI_BATCH);
    localparam logic [SHIFT-1:0] LAST = SHIFT'(MINI_BATCH - 1);
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic {COLLECT, OUT} state_t;

    state_t                state;
    logic [SHIFT-1:0]      cnt;
    logic [DATA_WIDTH-1:0] partsum_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] min_q;
    logic [ADDR_WIDTH-1:0] chan;
    logic                  accept;

    assign accept     = s_valid & s_ready;
    assign dp_valid   = accept;
    assign dp_x       = s_data;
    assign dp_partsum = partsum_q;
    assign dp_max     = max_q;
    assign dp_min     = min_q;
    assign dp_addr    = chan;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            partsum_q <= '0;
            max_q     <= SMIN;
            min_q     <= SMAX;
            chan      <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_mean    <= '0;
            m_max     <= '0;
            m_min     <= '0;
            m_range   <= '0;
            m_addr    <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        partsum_q <= dp_partsum_r;
                        max_q     <= dp_max_r;
                        min_q     <= dp_min_r;
                        cnt       <= cnt + 1'b1;
                        if (cnt == '0)
                            chan <= s_addr;
                        if (cnt == LAST) begin
                            state   <= OUT;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                            m_mean  <= $signed(dp_partsum_r) >>> SHIFT;
                            m_max   <= dp_max_r;
                            m_min   <= dp_min_r;
                            m_range <= dp_max_r - dp_min_r;
                            m_addr  <= chan;
                        end
                    end
                end
                OUT: begin
                    // Reseed so every sample of the next batch goes through the cell
                    if (m_ready) begin
                        state     <= COLLECT;
                        s_ready   <= 1'b1;
                        m_valid   <= 1'b0;
                        cnt       <= '0;
                        partsum_q <= '0;
                        max_q     <= SMIN;
                        min_q     <= SMAX;
                        chan      <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef SUM_SEQ_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (accept && cnt != '0 && s_addr != chan)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Scoreboard bench for sum_seq_ctrl with a behavioural sum-cell model.
// Batch statistics are predicted from the accepted sample list.
module tb_sum_seq_ctrl;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int AW = 3;

    typedef struct {
        int mean;
        int mx;
        int mn;
        int rng;
        int addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] dp_x, dp_partsum, dp_max, dp_min;
    logic          dp_valid;
    logic [AW-1:0] dp_addr;
    logic [DW-1:0] dp_partsum_r, dp_max_r, dp_min_r;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_mean, m_max, m_min, m_range;
    logic [AW-1:0] m_addr;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sum_seq_ctrl #(
        .DATA_WIDTH(DW),
        .MINI_BATCH(MB),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .s_addr(s_addr),
        .dp_x(dp_x),
        .dp_partsum(dp_partsum),
        .dp_max(dp_max),
        .dp_min(dp_min),
        .dp_valid(dp_valid),
        .dp_addr(dp_addr),
        .dp_partsum_r(dp_partsum_r),
        .dp_max_r(dp_max_r),
        .dp_min_r(dp_min_r),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_mean(m_mean),
        .m_max(m_max),
        .m_min(m_min),
        .m_range(m_range),
        .m_addr(m_addr),
        .err(err)
    );

    // Combinational sum cell as seen from the controller
    assign dp_partsum_r = dp_partsum + dp_x;
    assign dp_max_r = ($signed(dp_x) > $signed(dp_max)) ? dp_x : dp_max;
    assign dp_min_r = ($signed(dp_x) < $signed(dp_min)) ? dp_x : dp_min;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    function automatic exp_t predict(input int smp[$], input int a);
        exp_t e;
        int sum;
        int mx;
        int mn;
        int ws;
        logic [15:0] w;
        sum = 0;
        mx = smp[0];
        mn = smp[0];
        foreach (smp[i]) begin
            sum += smp[i];
            if (smp[i] > mx) mx = smp[i];
            if (smp[i] < mn) mn = smp[i];
        end
        w = sum[15:0];
        ws = int'($signed(w));
        e.mean = (ws >= 0) ? ws / MB : -((-ws + MB - 1) / MB);
        e.mx = mx;
        e.mn = mn;
        e.rng = (mx - mn) & 32'hFFFF;
        e.addr = a;
        return e;
    endfunction

    // Scoreboard state
    exp_t exp_q[$];
    int   batch[$];
    int   batch_addr;
    bit   mon_en = 1'b0;
    bit   model_err = 1'b0;
    bit   pend_mv = 1'b0;
    bit   hs_prev = 1'b0;
    bit   stall_prev = 1'b0;
    logic [DW-1:0] snap_mean, snap_max, snap_min, snap_range;
    logic [AW-1:0] snap_addr;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                batch.delete();
                exp_q.delete();
                model_err = 1'b0;
                pend_mv = 1'b0;
                hs_prev = 1'b0;
                stall_prev = 1'b0;
            end else begin
                exp_t e;
                chk("err", int'(err), int'(model_err));
                if (pend_mv)
                    chk("latency_m_valid", int'(m_valid), 1);
                if (m_valid)
                    chk("m_valid_expected", int'(exp_q.size() > 0), 1);
                if (hs_prev) begin
                    chk("return_s_ready", int'(s_ready), 1);
                    chk("return_m_valid", int'(m_valid), 0);
                end
                if (stall_prev && m_valid) begin
                    chk("stall_stable", int'({m_mean, m_max, m_min, m_range, m_addr} ==
                        {snap_mean, snap_max, snap_min, snap_range, snap_addr}), 1);
                end
                if (m_valid)
                    chk("s_ready_in_out", int'(s_ready), 0);
                if (s_valid) begin
                    chk("dp_valid", int'(dp_valid), int'(s_ready));
                    chk("dp_x", int'(dp_x), int'(s_data));
                end
                if (m_valid && m_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (int'($signed(m_mean)) != e.mean || int'($signed(m_max)) != e.mx ||
                        int'($signed(m_min)) != e.mn || int'(m_range) != e.rng ||
                        int'(m_addr) != e.addr) begin
                        miscompares++;
                        $display("FAIL stats: got mean=%0d max=%0d min=%0d range=%0d addr=%0d expected mean=%0d max=%0d min=%0d range=%0d addr=%0d",
                                 $signed(m_mean), $signed(m_max), $signed(m_min), m_range, m_addr,
                                 e.mean, e.mx, e.mn, e.rng, e.addr);
                    end
                end
                pend_mv = 1'b0;
                if (s_valid && s_ready) begin
                    if (batch.size() == 0)
                        batch_addr = int'(s_addr);
`ifdef SUM_SEQ_ADDR_CHECK_EN
                    else if (int'(s_addr) != batch_addr)
                        model_err = 1'b1;
`endif
                    batch.push_back(int'($signed(s_data)));
                    if (batch.size() == MB) begin
                        exp_q.push_back(predict(batch, batch_addr));
                        batch.delete();
                        pend_mv = 1'b1;
                    end
                end
                hs_prev = m_valid && m_ready;
                stall_prev = m_valid && !m_ready;
                snap_mean = m_mean;
                snap_max = m_max;
                snap_min = m_min;
                snap_range = m_range;
                snap_addr = m_addr;
            end
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic [AW-1:0] a);
        bit ok;
        int n;
        s_valid = 1'b1;
        s_data = d;
        s_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok)
            chk("beat_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300)
            chk("drain_timeout", 0, 1);
    endtask

    bit rand_done;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_addr = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_partsum", int'(dp_partsum), 0);
        chk("rst_max", int'(dp_max), 'h8000);
        chk("rst_min", int'(dp_min), 'h7FFF);
        chk("rst_addr", int'(dp_addr), 0);
        chk("rst_mdata", int'({m_mean, m_max, m_min, m_range} == '0), 1);
        rst = 1'b0;
        mon_en = 1'b1;

        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) beat(DW'(i), 3'd5);
        idle(0);
        drain();
        for (int i = -8; i <= -1; i++) beat(DW'(i), 3'd2);
        idle(0);
        drain();
        for (int i = 0; i < 4; i++) begin
            beat(16'h7FFF, 3'd1);
            beat(16'h8000, 3'd1);
        end
        idle(0);
        drain();

        // Gaps on input and a downstream stall with extra offered beats
        m_ready = 1'b0;
        beat(16'd1, 3'd5);
        beat(16'd2, 3'd5);
        idle(2);
        beat(16'd3, 3'd5);
        beat(16'd4, 3'd5);
        idle(1);
        for (int i = 5; i <= 8; i++) beat(DW'(i), 3'd5);
        s_valid = 1'b1;
        s_data = 16'h1234;
        s_addr = 3'd7;
        for (int n = 0; n < 50 && !m_valid; n++) @(negedge clk);
        chk("stall_m_valid_seen", int'(m_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
        s_valid = 1'b0;
        drain();

        // Reset mid-batch
        for (int i = 0; i < 3; i++) beat(16'd100, 3'd6);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'd2, 3'd6);
        idle(0);
        drain();

        // Address mismatch on beat 2
        for (int i = 0; i < 8; i++) beat(DW'(10 * i), (i == 2) ? 3'd4 : 3'd3);
        idle(3);
        drain();

        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    logic [AW-1:0] a;
                    a = AW'($urandom_range(0, 7));
                    for (int i = 0; i < MB; i++) begin
                        if ($urandom_range(0, 3) == 0)
                            idle($urandom_range(1, 2));
                        beat(DW'($urandom), a);
                    end
                    idle(0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        m_ready = 1'b1;
        drain();
        idle(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sum_seq_ctrl.md
Name: sum_seq_ctrl

Overview:
- Sequencer for the range-BN sum cell. It time-multiplexes one combinational sum cell across a mini-batch.
- Accepts a sample stream per channel and feeds the cell with registered partial-sum, max and min. It counts MINI_BATCH accepted samples, then presents per-channel mean, max, min and range on a valid/ready output.
- Sits between the activation buffer and the normalisation stage.

Parameters:
- DATA_WIDTH, 16, sample/statistic width, signed two's complement
- MINI_BATCH, 8, samples per channel; power of two, >=2
- ADDR_WIDTH, 3, channel address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_data  in  DATA_WIDTH  signed sample
- s_addr  in  ADDR_WIDTH  channel address of the sample
- dp_x  out  DATA_WIDTH  to cell x_in (= s_data)
- dp_partsum  out  DATA_WIDTH  to cell partsum_in (accumulator register)
- dp_max  out  DATA_WIDTH  to cell max_in (max register)
- dp_min  out  DATA_WIDTH  to cell min_in (min register)
- dp_valid  out  1  to cell valid_in
- dp_addr  out  ADDR_WIDTH  to cell addr_in (latched channel)
- dp_partsum_r  in  DATA_WIDTH  from cell partsum_out
- dp_max_r  in  DATA_WIDTH  from cell max_out
- dp_min_r  in  DATA_WIDTH  from cell min_out
- m_valid  out  1  statistics valid
- m_ready  in  1  downstream accepts statistics
- m_mean  out  DATA_WIDTH  signed, partsum >>> log2(MINI_BATCH)
- m_max  out  DATA_WIDTH  signed batch max
- m_min  out  DATA_WIDTH  signed batch min
- m_range  out  DATA_WIDTH  unsigned, max - min modulo 2^DATA_WIDTH
- m_addr  out  ADDR_WIDTH  channel address
- err  out  1  sticky address-mismatch flag (optional feature only, else tied 0)

Behaviour:
- Reset: state COLLECT, cnt=0, partsum=0, max=most negative (0x8000 at 16b), min=most positive (0x7FFF), chan=0, m_valid=0, err=0. All m_* data registers are 0.
- Seed: the register values above are the reset/reload seed. All MINI_BATCH samples pass through the cell; there is no special first-sample path.
- COLLECT state:
  - s_ready=1, m_valid=0.
  - dp_valid = s_valid & s_ready (combinational). dp_x = s_data.
  - On accept (s_valid & s_ready): partsum <= dp_partsum_r, max <= dp_max_r, min <= dp_min_r, cnt++.
  - When cnt==0, chan <= s_addr. Later beats' s_addr are ignored except for the optional check.
  - Without accept: registers hold; idle s_valid gaps are allowed.
  - Accept with cnt==MINI_BATCH-1: next cycle, state OUT and m_valid=1.
- Statistics capture (registered, on the final accept):
  - m_mean = dp_partsum_r arithmetic-shifted right by log2(MINI_BATCH), i.e. floor division.
  - m_max = dp_max_r, m_min = dp_min_r, m_addr = chan.
  - m_range = dp_max_r - dp_min_r, DATA_WIDTH bits, unsigned interpretation.
- Overflow: partsum wraps at DATA_WIDTH, matching the cell. No saturation.
- OUT state:
  - s_ready=0, dp_valid=0. m_* stable while m_valid & !m_ready.
  - On m_ready: m_valid<=0, registers reseeded, cnt<=0, state COLLECT.
  - Throughput: MINI_BATCH+1 cycles per channel minimum (one-cycle bubble).
- Latency: m_valid rises 1 cycle after the final sample accept.
- Reset mid-batch: partial state is discarded; the next sample starts a fresh batch.
- m_ready while m_valid=0 is ignored.
- dp_addr = chan at all times.

Optional Feature:
- Macro: SUM_SEQ_ADDR_CHECK_EN.
- Defined:
  - On any accept with cnt!=0 and s_addr!=chan, err<=1 (sticky until rst).
  - The sample is still accumulated.
- Undefined: err is tied 0 and no comparator is built.

Test Plan:
- Samples 1..8, addr 5, s_valid continuous, m_ready=1 -> m_valid 1 cycle after 8th accept; mean=4, max=8, min=1, range=7, addr=5; back in COLLECT the following cycle.
- Samples -8..-1 -> sum -36, mean=-5 (floor), max=-1, min=-8, range=7.
- Alternating 0x7FFF/0x8000 x4 pairs -> sum wraps to -4, mean=-1, max=0x7FFF, min=0x8000, range=0xFFFF.
- Samples 1..8 with s_valid low on cycles 2,3,6, then m_ready held low 5 cycles:
  - stats identical to the first case;
  - m_* stable and s_ready=0 while stalled;
  - extra s_valid beats are not consumed.
- Three samples of 100, then rst for 1 cycle, then 8 samples of 2 -> mean=2, max=2, min=2, range=0; no m_valid before the 8th post-reset accept.
- With SUM_SEQ_ADDR_CHECK_EN: addr 3 on beat 0 and addr 4 on beat 2 -> err=1 from the cycle after beat 2 and stays set; m_addr=3 and stats are unaffected. Without the macro, err stays 0.
